sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data width of SRAM word and request/response data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning the SRAM word-address width.
REQ-003 The block SHALL have these ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- req0_valid / req1_valid  input  1  requester 0/1 has a request.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_wen / req1_wen  input  1  1 = write, 0 = read.
- req0_addr / req1_addr  input  ADDR_WIDTH  word address.
- req0_wdata / req1_wdata  input  DATA_WIDTH  write data.
- rsp0_valid / rsp1_valid  output  1  read data valid for requester 0/1.
- rsp0_ready / rsp1_ready  input  1  requester 0/1 takes the response.
- rsp0_rdata / rsp1_rdata  output  DATA_WIDTH  read data.
- sram_a  output  ADDR_WIDTH  SRAM address.
- sram_d  output  DATA_WIDTH  SRAM write data.
- sram_wen  output  DATA_WIDTH  SRAM write enable; all ones = write, all zeros = no write.
- sram_q  input  DATA_WIDTH  SRAM read data, registered, valid the cycle after the address is presented.

Function
REQ-004 The FSM SHALL have the states IDLE, RESP and HOLD.
REQ-005 In IDLE with at least one valid request, the block SHALL grant exactly one requester:
- The winner's reqN_ready = 1 in the same cycle, combinationally.
- The loser's ready = 0.
REQ-006 On grant, the block SHALL drive the winner's addr onto sram_a and its wdata onto sram_d.
- sram_wen SHALL be all ones for a write and all zeros for a read.
REQ-007 When no request is granted, the block SHALL drive sram_a = 0, sram_d = 0 and sram_wen = 0.
REQ-008 An accepted write SHALL complete in its acceptance cycle, SHALL produce no response, and the FSM SHALL stay in IDLE, so one write is accepted per cycle.
REQ-009 An accepted read SHALL record the owner and move the FSM to RESP.
REQ-010 In RESP, the block SHALL assert the owner's rspN_valid with rspN_rdata = sram_q.
- If the owner's rsp_ready = 1: go to IDLE.
- Otherwise: capture sram_q into a hold register and go to HOLD.
REQ-011 In HOLD, the block SHALL assert the owner's rspN_valid with rspN_rdata = hold register.
- rdata SHALL stay stable until rsp_ready = 1, then the FSM goes to IDLE.
REQ-012 In RESP and HOLD, both req_ready outputs SHALL be 0 and the SRAM SHALL be idle per REQ-007, so a read takes at minimum 2 cycles from acceptance to the next acceptance.
REQ-013 The non-owner's rsp_valid SHALL always be 0, and rsp_rdata SHALL be 0 whenever its rsp_valid = 0.
REQ-014 A request whose valid drops before acceptance SHALL be dropped with no side effect.
- Once valid is asserted, the requester holds addr, wen and wdata stable until ready.

Reset
REQ-015 Assertion of RST_N = 0 SHALL immediately force the FSM to IDLE, the hold register to 0, the owner to 0 and the round-robin pointer to favour requester 0.
- All outputs SHALL go to 0.
REQ-016 A reset in RESP or HOLD SHALL discard the pending read response.
- The first grant after RST_N rises SHALL occur no earlier than the first rising edge after deassertion.

Configuration
REQ-017 With macro SRAM_ARB_RR_EN defined, arbitration SHALL be round-robin:
- On simultaneous valid, grant the requester not granted last.
- The pointer updates on every accepted request.
- After reset, requester 0 wins.
REQ-018 Without SRAM_ARB_RR_EN, requester 0 SHALL always win simultaneous requests, and no pointer state SHALL exist.

Verification
REQ-019 Write/read back: req0 write addr 0x05 data 0xDEADBEEF, then req0 read 0x05 -> rsp0_valid 1 cycle after acceptance with rdata 0xDEADBEEF; write gets no response.
REQ-020 Response backpressure: req1 read 0x05, rsp1_ready held 0 for 3 cycles -> rsp1_valid held 4 cycles, rdata stable at 0xDEADBEEF, both req_ready 0 throughout.
REQ-021 Contention: both valid reads every cycle for 4 grants -> with SRAM_ARB_RR_EN, grant order 0,1,0,1; without it, 0,0,0,0 and req1 starved.
REQ-022 Back-to-back writes: req0 writes 0x00..0x03 on 4 consecutive cycles -> ready high all 4 cycles, sram_wen all ones each cycle; readback returns the written values.
REQ-023 Reset mid-operation: RST_N low while in HOLD -> all outputs 0 asynchronously, no rsp_valid after release; the next read of 0x05 returns 0xDEADBEEF.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port request arbiter in front of a single-port SRAM with a registered read port.
// Writes complete in their acceptance cycle. A read occupies the SRAM until its
// response is taken. When a response is not taken at once, a hold register keeps
// its data stable.
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration. Without it,
// requester 0 has fixed priority.
module sram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wen,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wen,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  gnt0, gnt1, accept;
  logic                  sel_wen;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rsp_active, rsp_take;
  logic [DATA_WIDTH-1:0] rsp_data;

`ifdef SRAM_ARB_RR_EN
  // 1 = requester 1 wins the next simultaneous request
  logic rr_ptr_q;

  // Pointer favours the requester that did not win the last accepted request
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      rr_ptr_q <= 1'b0;
    else if (accept) rr_ptr_q <= gnt0;
  end
`endif

  // Grant only in IDLE and never while reset is asserted, so outputs read 0 during reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RST_N && state_q == IDLE) begin
`ifdef SRAM_ARB_RR_EN
      if (req0_valid && req1_valid) begin
        gnt0 = !rr_ptr_q;
        gnt1 = rr_ptr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`else
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
`endif
    end
  end

  assign accept     = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_wen   = gnt1 ? req1_wen   : req0_wen;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;

  // SRAM port carries the granted request; otherwise it is held fully idle
  always_comb begin
    sram_a   = '0;
    sram_d   = '0;
    sram_wen = '0;
    if (accept) begin
      sram_a   = sel_addr;
      sram_d   = sel_wdata;
      sram_wen = sel_wen ? '1 : '0;
    end
  end

  assign rsp_active = (state_q == RESP) || (state_q == HOLD);
  assign rsp_data   = (state_q == RESP) ? sram_q : hold_q;
  assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

  // Only the owner sees a response; rdata is forced to 0 whenever valid is low
  always_comb begin
    rsp0_valid = rsp_active && !owner_q;
    rsp1_valid = rsp_active &&  owner_q;
    rsp0_rdata = rsp0_valid ? rsp_data : '0;
    rsp1_rdata = rsp1_valid ? rsp_data : '0;
  end

  // Next state: reads go to RESP. A response that is not taken parks sram_q in HOLD.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept && !sel_wen) begin
          state_d = RESP;
          owner_d = gnt1;
        end
      end
      RESP: begin
        if (rsp_take) begin
          state_d = IDLE;
        end else begin
          hold_d  = sram_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rsp_take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. An asynchronous reset discards any pending read response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural registered-read SRAM.
// The bench works with SRAM_ARB_RR_EN either defined or undefined.
module tb_sram_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          req0_valid, req0_ready, req0_wen;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_wen;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_wen, sram_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q)
  );

  always #5 CLK = ~CLK;

  // SRAM model: write on all-ones enable, read data registered one cycle after the address
  always @(posedge CLK) begin
    if (sram_wen == ALL1) mem[sram_a] <= sram_d;
    sram_q <= mem[sram_a];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_req(input int p, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0_valid = v; req0_wen = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_wen = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [DW-1:0] rspd(input int p);
    return (p == 0) ? rsp0_rdata : rsp1_rdata;
  endfunction

  // Each transaction task starts and ends 1 time unit after a rising edge
  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive_req(p, 1'b1, 1'b1, a, d);
    @(negedge CLK);
    check("wr_ready", rdy(p), 1);
    check("wr_other_ready", rdy(1 - p), 0);
    check("wr_sram_wen", sram_wen, ALL1);
    check("wr_sram_a", sram_a, a);
    check("wr_sram_d", sram_d, d);
    @(posedge CLK); #1;
    drive_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive_req(p, 1'b1, 1'b0, a, '0);
    @(negedge CLK);
    check("rd_ready", rdy(p), 1);
    check("rd_sram_wen", sram_wen, 0);
    check("rd_sram_a", sram_a, a);
    @(posedge CLK); #1;
    drive_req(p, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    check("rd_rsp_valid", rspv(p), 1);
    check("rd_rsp_rdata", rspd(p), exp);
    check("rd_other_valid", rspv(1 - p), 0);
    check("rd_other_rdata", rspd(1 - p), 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int exp_order[4];
    RST_N = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive_req(0, 1'b1, 1'b1, 10'd3, 32'h1111);
    drive_req(1, 1'b0, 1'b0, '0, '0);

    // Reset state: everything 0 even with a request pending
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_sram_wen", sram_wen, 0);
    check("rst_sram_a", sram_a, 0);
    check("rst_sram_d", sram_d, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    drive_req(0, 1'b0, 1'b0, '0, '0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Write then read back; the write produces no response
    do_write(0, 10'h005, 32'hDEADBEEF);
    @(negedge CLK);
    check("wr_no_rsp0", rsp0_valid, 0);
    check("idle_sram_wen", sram_wen, 0);
    check("idle_sram_a", sram_a, 0);
    @(posedge CLK); #1;
    do_read(0, 10'h005, 32'hDEADBEEF);

    // Response backpressure on requester 1 with requester 0 waiting
    rsp1_ready = 1'b0;
    drive_req(1, 1'b1, 1'b0, 10'h005, '0);
    @(negedge CLK);
    check("bp_req1_ready", req1_ready, 1);
    @(posedge CLK); #1;
    drive_req(1, 1'b0, 1'b0, '0, '0);
    drive_req(0, 1'b1, 1'b1, 10'h007, 32'h77);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rsp1_ready = 1'b1;
      @(negedge CLK);
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp1_rdata", rsp1_rdata, 32'hDEADBEEF);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_req1_ready", req1_ready, 0);
      check("bp_sram_wen", sram_wen, 0);
      check("bp_rsp0_valid", rsp0_valid, 0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("bp_after_rsp1_valid", rsp1_valid, 0);
    check("bp_after_req0_ready", req0_ready, 1);
    check("bp_after_sram_a", sram_a, 7);
    @(posedge CLK); #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);

    // Back-to-back writes, one per cycle, then read back
    for (int i = 0; i < 4; i++) begin
      drive_req(0, 1'b1, 1'b1, AW'(i), 32'hA0 + DW'(i));
      @(negedge CLK);
      check("b2b_ready", req0_ready, 1);
      check("b2b_sram_wen", sram_wen, ALL1);
      check("b2b_sram_a", sram_a, i);
      @(posedge CLK); #1;
    end
    drive_req(0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) do_read(0, AW'(i), 32'hA0 + DW'(i));

    // Reset while in HOLD
    rsp0_ready = 1'b0;
    drive_req(0, 1'b1, 1'b0, 10'h005, '0);
    @(negedge CLK);
    check("hr_ready", req0_ready, 1);
    @(posedge CLK); #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    check("hr_resp_valid", rsp0_valid, 1);
    @(posedge CLK); #1;
    drive_req(1, 1'b1, 1'b1, 10'h009, 32'h99);
    @(negedge CLK);
    check("hr_hold_valid", rsp0_valid, 1);
    check("hr_hold_rdata", rsp0_rdata, 32'hDEADBEEF);
    #2 RST_N = 1'b0;
    #1;
    check("hr_async_rsp0_valid", rsp0_valid, 0);
    check("hr_async_rsp0_rdata", rsp0_rdata, 0);
    check("hr_async_req1_ready", req1_ready, 0);
    check("hr_async_sram_wen", sram_wen, 0);
    check("hr_async_sram_a", sram_a, 0);
    @(posedge CLK);
    @(negedge CLK);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    RST_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check("hr_post_rsp0_valid", rsp0_valid, 0);
      check("hr_post_rsp1_valid", rsp1_valid, 0);
    end
    @(posedge CLK); #1;
    do_read(0, 10'h005, 32'hDEADBEEF);

    // Fresh reset so arbitration starts from its reset preference
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Contention: both requesters read every cycle for four grants
`ifdef SRAM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive_req(0, 1'b1, 1'b0, 10'h005, '0);
    drive_req(1, 1'b1, 1'b0, 10'h007, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("ct_grant", {req1_ready, req0_ready}, (exp_order[k] == 1) ? 2'b10 : 2'b01);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("ct_rsp_valid", rspv(exp_order[k]), 1);
      check("ct_rsp_rdata", rspd(exp_order[k]),
            (exp_order[k] == 1) ? 32'h77 : 32'hDEADBEEF);
      check("ct_busy_ready", {req1_ready, req0_ready}, 2'b00);
      @(posedge CLK); #1;
    end
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
